csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Sequences CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) as read-modify-write operations on a single-port, synchronous-read CSR RAM (12-bit address, MXLEN data).
- Arbitrates that RAM between the instruction path (decode/execute) and trap-unit writes (mepc/mcause/mtval); trap writes have priority.
- Returns the old CSR value to the GPR writeback path.

Parameters:
- MXLEN, 32, CSR/GPR data width (32 or 64)
- CSR_AW, 12, CSR address width

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous reset, active low
- i_req_valid  in  1  CSR instruction request
- o_req_ready  out  1  request accepted when valid & ready
- i_funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- i_csr_addr  in  CSR_AW  target CSR
- i_rs1_addr_uimm  in  5  rs1 index or zimm
- i_rd_addr  in  5  destination GPR
- i_rs1_data  in  MXLEN  rs1 value
- i_trap_valid  in  1  trap-unit write request
- o_trap_ready  out  1  trap write accepted this cycle
- i_trap_addr  in  CSR_AW  trap write address
- i_trap_data  in  MXLEN  trap write data
- o_ram_en  out  1  RAM access enable
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  CSR_AW  RAM address
- o_ram_wdata  out  MXLEN  RAM write data
- i_ram_rdata  in  MXLEN  RAM read data, valid one cycle after a read
- o_rd_valid  out  1  one-cycle pulse: o_rd_data valid for GPR write
- o_rd_addr  out  5  GPR index
- o_rd_data  out  MXLEN  old CSR value
- o_illegal  out  1  one-cycle pulse: illegal access (see Optional Feature)
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_nrst=0): state=IDLE.
  - Registered outputs cleared: o_rd_valid=0, o_rd_addr=0, o_rd_data=0, o_illegal=0.
  - RAM controls are forced to 0 asynchronously while reset is asserted.
- FSM states: IDLE, RD, WB, RSP.
- IDLE:
  - If i_trap_valid: o_trap_ready=1, o_req_ready=0; in the same cycle o_ram_en=1, o_ram_we=1, addr/wdata taken from the trap inputs. Stay in IDLE.
  - Else o_req_ready=1. On handshake, latch funct3, addr, uimm, rd, rs1_data; go to RD.
- RD: o_ram_en=1, o_ram_we=0, o_ram_addr=latched addr. Go to WB.
- WB:
  - old = i_ram_rdata.
  - src = rs1_data for funct3[2]=0; src = zero-extended uimm for funct3[2]=1.
  - RW/RWI: new = src; write always.
  - RS/RSI: new = old | src; write only if uimm/rs1 index != 0.
  - RC/RCI: new = old & ~src; write only if uimm/rs1 index != 0.
  - When writing: o_ram_en=o_ram_we=1, same address, o_ram_wdata=new.
  - Go to RSP; capture old into o_rd_data.
- RSP:
  - o_rd_valid=1 only if latched rd != 0; o_rd_addr=latched rd.
  - Go to IDLE.
  - o_trap_ready=0 and o_req_ready=0 in every non-IDLE state, so trap requests wait. A trap asserted mid-operation is served in the first IDLE cycle.
- Latency: handshake at cycle T, read at T+1, write at T+2, o_rd_valid at T+3. Throughput is one request per 4 cycles.
- Invalid funct3 (000, 100): accepted, no RAM access, jump directly to RSP with o_rd_valid=0 and o_illegal=1.
- No RAM write occurs outside IDLE (trap) or WB.
- Reset asserted in any state aborts the operation with no partial write. A request in flight is dropped, not replayed.
- Data width: all arithmetic is MXLEN bits; uimm is zero-extended to MXLEN.

Optional Feature:
- CSR_RO_CHECK_EN defined:
  - Any instruction write to an address with addr[11:10]==2'b11 (read-only space) is suppressed (o_ram_we=0 in WB).
  - o_illegal pulses in RSP and o_rd_valid is held at 0.
  - CSRRS/CSRRC with rs1/uimm index 0 are not writes and complete normally.
  - Trap writes are never checked.
- Not defined: no check; such writes proceed and o_illegal pulses only for invalid funct3.

Test Plan:
- CSR[0x340]=0x0000_00F0; CSRRS rd=5, rs1_data=0x0F, rs1 index 3.
  - Expected: RAM writes 0x0000_00FF at T+2; o_rd_valid at T+3 with rd=5, data=0x0000_00F0.
- CSR[0x340]=0xFF; CSRRCI uimm=0, rd=0.
  - Expected: no RAM write; o_rd_valid never asserted; returns to IDLE at T+4.
- CSRRWI uimm=0x1F to 0x305, rd=7, old value 0x8000_0000.
  - Expected: RAM writes 0x0000_001F; rd data 0x8000_0000.
- i_trap_valid and i_req_valid asserted together in IDLE (trap addr 0x341, data 0x1234).
  - Expected: trap written that cycle, o_req_ready=0.
  - The request is accepted the next cycle.
- i_nrst pulsed low during WB.
  - Expected: o_ram_we drops immediately, no write, all outputs 0, state IDLE.
- With CSR_RO_CHECK_EN defined: CSRRW to 0xF11, rd=1.
  - Expected: no write, o_illegal pulse at T+3, o_rd_valid=0.
- Without CSR_RO_CHECK_EN: the same CSRRW writes and returns old data.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// CSR instruction sequencer: read-modify-write on a single-port CSR RAM, with trap-unit writes taking priority.
// Optional macro CSR_RO_CHECK_EN suppresses instruction writes to read-only CSR space (addr[11:10]==2'b11).
module csr_access_ctrl #(
    parameter int unsigned MXLEN  = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_funct3,
    input  logic [CSR_AW-1:0] i_csr_addr,
    input  logic [4:0]        i_rs1_addr_uimm,
    input  logic [4:0]        i_rd_addr,
    input  logic [MXLEN-1:0]  i_rs1_data,
    input  logic              i_trap_valid,
    output logic              o_trap_ready,
    input  logic [CSR_AW-1:0] i_trap_addr,
    input  logic [MXLEN-1:0]  i_trap_data,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [CSR_AW-1:0] o_ram_addr,
    output logic [MXLEN-1:0]  o_ram_wdata,
    input  logic [MXLEN-1:0]  i_ram_rdata,
    output logic              o_rd_valid,
    output logic [4:0]        o_rd_addr,
    output logic [MXLEN-1:0]  o_rd_data,
    output logic              o_illegal,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WB   = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [CSR_AW-1:0]   addr_q, addr_d;
    logic [4:0]          uimm_q, uimm_d;
    logic [4:0]          rd_q, rd_d;
    logic [MXLEN-1:0]    rs1_q, rs1_d;
    logic [MXLEN-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                illegal_q, illegal_d;

    logic                req_ready_c;
    logic                trap_ready_c;
    logic                ram_en_c;
    logic                ram_we_c;
    logic [CSR_AW-1:0]   ram_addr_c;
    logic [MXLEN-1:0]    ram_wdata_c;

    logic [MXLEN-1:0]    src_c;
    logic [MXLEN-1:0]    new_c;
    logic                wants_write_c;
    logic                ro_fault_c;
    logic                do_write_c;

    // Modify step: operand select, new value and write qualification
    always_comb begin
        src_c = funct3_q[2] ? MXLEN'(uimm_q) : rs1_q;
        case (funct3_q[1:0])
            2'b01:   new_c = src_c;
            2'b10:   new_c = i_ram_rdata | src_c;
            2'b11:   new_c = i_ram_rdata & ~src_c;
            default: new_c = i_ram_rdata;
        endcase
        // Set/clear with index 0 is a pure read
        wants_write_c = (funct3_q[1:0] == 2'b01) || (uimm_q != 5'd0);
`ifdef CSR_RO_CHECK_EN
        ro_fault_c = wants_write_c && (addr_q[CSR_AW-1 -: 2] == 2'b11);
`else
        ro_fault_c = 1'b0;
`endif
        do_write_c = wants_write_c && !ro_fault_c;
    end

    // Next state, latched operands and RAM port control
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        uimm_d       = uimm_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        illegal_d    = 1'b0;
        req_ready_c  = 1'b0;
        trap_ready_c = 1'b0;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;
        ram_addr_c   = addr_q;
        ram_wdata_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (i_trap_valid) begin
                    trap_ready_c = 1'b1;
                    ram_en_c     = 1'b1;
                    ram_we_c     = 1'b1;
                    ram_addr_c   = i_trap_addr;
                    ram_wdata_c  = i_trap_data;
                end else begin
                    req_ready_c = 1'b1;
                    if (i_req_valid) begin
                        funct3_d = i_funct3;
                        addr_d   = i_csr_addr;
                        uimm_d   = i_rs1_addr_uimm;
                        rd_d     = i_rd_addr;
                        rs1_d    = i_rs1_data;
                        if (i_funct3[1:0] == 2'b00) begin
                            illegal_d = 1'b1;
                            state_d   = S_RSP;
                        end else begin
                            state_d   = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                ram_en_c = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                rd_data_d = i_ram_rdata;
                if (do_write_c) begin
                    ram_en_c    = 1'b1;
                    ram_we_c    = 1'b1;
                    ram_wdata_c = new_c;
                end
                rd_valid_d = (rd_q != 5'd0) && !ro_fault_c;
                illegal_d  = ro_fault_c;
                state_d    = S_RSP;
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            uimm_q     <= 5'd0;
            rd_q       <= 5'd0;
            rs1_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            uimm_q     <= uimm_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    // Reset kills the RAM port and handshakes immediately so no partial write can land
    assign o_ram_en     = ram_en_c & i_nrst;
    assign o_ram_we     = ram_we_c & i_nrst;
    assign o_ram_addr   = i_nrst ? ram_addr_c : '0;
    assign o_ram_wdata  = i_nrst ? ram_wdata_c : '0;
    assign o_req_ready  = req_ready_c & i_nrst;
    assign o_trap_ready = trap_ready_c & i_nrst;

    assign o_rd_valid = rd_valid_q;
    assign o_rd_addr  = rd_q;
    assign o_rd_data  = rd_data_q;
    assign o_illegal  = illegal_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed vector bench for csr_access_ctrl with a behavioural synchronous-read CSR RAM.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  uimm;
    logic [4:0]  rd_addr_in;
    logic [31:0] rs1_data;
    logic        trap_valid;
    logic        trap_ready;
    logic [11:0] trap_addr;
    logic [31:0] trap_data;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        rd_valid;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:4095];

    csr_access_ctrl #(.MXLEN(32), .CSR_AW(12)) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_funct3(funct3), .i_csr_addr(csr_addr),
        .i_rs1_addr_uimm(uimm), .i_rd_addr(rd_addr_in), .i_rs1_data(rs1_data),
        .i_trap_valid(trap_valid), .o_trap_ready(trap_ready),
        .i_trap_addr(trap_addr), .i_trap_data(trap_data),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
        .o_rd_valid(rd_valid), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_illegal(illegal), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] init;
        logic        wr;
        logic [31:0] newv;
        logic        rdv;
        logic        ill;
    } vec_t;

    localparam int unsigned NVEC = 8;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic to_drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic trap_write(input logic [11:0] a, input logic [31:0] d, input string nm);
        trap_valid = 1'b1;
        trap_addr  = a;
        trap_data  = d;
        @(negedge clk);
        chk({nm, " trap_ready"}, 32'(trap_ready), 32'd1);
        to_drive_edge();
        trap_valid = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [11:0] a, input logic [4:0] idx,
                             input logic [4:0] rd, input logic [31:0] d);
        req_valid  = 1'b1;
        funct3     = f;
        csr_addr   = a;
        uimm       = idx;
        rd_addr_in = rd;
        rs1_data   = d;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        trap_write(v.addr, v.init, p);
        drive_req(v.f3, v.addr, v.idx, v.rd, v.rs1);
        @(negedge clk);
        chk({p, " req_ready"}, 32'(req_ready), 32'd1);
        to_drive_edge();
        req_valid = 1'b0;
        @(negedge clk);                                  // T+1: read
        chk({p, " rd_en"}, 32'({ram_en, ram_we}), 32'b10);
        chk({p, " rd_addr_port"}, 32'(ram_addr), 32'(v.addr));
        @(negedge clk);                                  // T+2: write
        chk({p, " we"}, 32'(ram_we), 32'(v.wr));
        if (v.wr) chk({p, " wdata"}, ram_wdata, v.newv);
        @(negedge clk);                                  // T+3: response
        chk({p, " rd_valid"}, 32'(rd_valid), 32'(v.rdv));
        chk({p, " illegal"}, 32'(illegal), 32'(v.ill));
        chk({p, " ram_en_rsp"}, 32'(ram_en), 32'd0);
        if (v.rdv) begin
            chk({p, " rd_data"}, rd_data, v.init);
            chk({p, " rd_idx"}, 32'(rd_addr), 32'(v.rd));
        end
        @(negedge clk);                                  // T+4: idle again
        chk({p, " busy_end"}, 32'(busy), 32'd0);
        chk({p, " mem"}, mem[v.addr], v.wr ? v.newv : v.init);
        to_drive_edge();
    endtask

    initial begin
        vecs[0] = '{3'b010, 12'h340, 5'd3,  5'd5, 32'h0000_000F, 32'h0000_00F0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0};
        vecs[1] = '{3'b111, 12'h340, 5'd0,  5'd0, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[2] = '{3'b101, 12'h305, 5'h1F, 5'd7, 32'h0,         32'h8000_0000, 1'b1, 32'h0000_001F, 1'b1, 1'b0};
`ifdef CSR_RO_CHECK_EN
        vecs[3] = '{3'b001, 12'hF11, 5'd2,  5'd1, 32'h0000_ABCD, 32'h0000_0011, 1'b0, 32'h0,         1'b0, 1'b1};
`else
        vecs[3] = '{3'b001, 12'hF11, 5'd2,  5'd1, 32'h0000_ABCD, 32'h0000_0011, 1'b1, 32'h0000_ABCD, 1'b1, 1'b0};
`endif
        vecs[4] = '{3'b011, 12'h300, 5'd4,  5'd3, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FF0F, 1'b1, 1'b0};
        vecs[5] = '{3'b110, 12'h304, 5'h0A, 5'd9, 32'hFFFF_FFFF, 32'h0000_0100, 1'b1, 32'h0000_010A, 1'b1, 1'b0};
        vecs[6] = '{3'b010, 12'hC00, 5'd0,  5'd2, 32'hFFFF_FFFF, 32'h0000_0055, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[7] = '{3'b001, 12'h341, 5'd1,  5'd0, 32'h0000_DEAD, 32'h0000_0005, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0};

        nrst = 1'b0; req_valid = 1'b0; funct3 = 3'd0; csr_addr = 12'd0; uimm = 5'd0;
        rd_addr_in = 5'd0; rs1_data = 32'd0; trap_valid = 1'b1; trap_addr = 12'h341;
        trap_data = 32'hFFFF_FFFF; ram_rdata = 32'd0;

        // Reset state: RAM port forced low even with a pending trap
        #1;
        chk("rst ram_en", 32'({ram_en, ram_we}), 32'd0);
        chk("rst trap_ready", 32'(trap_ready), 32'd0);
        chk("rst outs", 32'({rd_valid, illegal, busy}), 32'd0);
        chk("rst rd_addr", 32'(rd_addr), 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        trap_valid = 1'b0;
        nrst = 1'b1;
        to_drive_edge();

        for (int i = 0; i < int'(NVEC); i++) run_vec(i, vecs[i]);

        // Invalid funct3: straight to response, illegal pulse, no RAM access
        drive_req(3'b100, 12'h340, 5'd3, 5'd6, 32'h1);
        to_drive_edge();
        req_valid = 1'b0;
        @(negedge clk);
        chk("bad_f3 illegal", 32'(illegal), 32'd1);
        chk("bad_f3 rd_valid", 32'(rd_valid), 32'd0);
        chk("bad_f3 ram_en", 32'(ram_en), 32'd0);
        @(negedge clk);
        chk("bad_f3 done", 32'({busy, illegal}), 32'd0);
        to_drive_edge();

        // Trap and request together: trap first, request accepted next cycle
        trap_valid = 1'b1; trap_addr = 12'h341; trap_data = 32'h0000_1234;
        drive_req(3'b010, 12'h341, 5'd0, 5'd4, 32'h0);
        @(negedge clk);
        chk("col req_ready", 32'(req_ready), 32'd0);
        chk("col trap_ready", 32'(trap_ready), 32'd1);
        chk("col ram_ctl", 32'({ram_en, ram_we}), 32'b11);
        chk("col wdata", ram_wdata, 32'h0000_1234);
        to_drive_edge();
        trap_valid = 1'b0;
        @(negedge clk);
        chk("col req_ready2", 32'(req_ready), 32'd1);
        to_drive_edge();
        req_valid  = 1'b0;
        trap_valid = 1'b1; trap_addr = 12'h342; trap_data = 32'h0000_00AA;
        @(negedge clk);
        chk("col trap_wait", 32'({trap_ready, ram_we}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("col rd_valid", 32'(rd_valid), 32'd1);
        chk("col rd_data", rd_data, 32'h0000_1234);
        chk("col trap_wait_rsp", 32'(trap_ready), 32'd0);
        @(negedge clk);
        chk("col trap_served", 32'(trap_ready), 32'd1);
        to_drive_edge();
        trap_valid = 1'b0;
        chk("col trap_mem", mem[12'h342], 32'h0000_00AA);

        // Reset during WB: write dropped, everything back to idle
        trap_write(12'h340, 32'h0000_0077, "rstwb");
        drive_req(3'b001, 12'h340, 5'd1, 5'd8, 32'h0000_0099);
        to_drive_edge();
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwb we_pre", 32'(ram_we), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rstwb ram_ctl", 32'({ram_en, ram_we}), 32'd0);
        chk("rstwb outs", 32'({rd_valid, illegal, busy}), 32'd0);
        chk("rstwb rd_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("rstwb mem", mem[12'h340], 32'h0000_0077);
        chk("rstwb busy", 32'({busy, rd_valid}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
